bitty_retire_tracker: RTL

//  Upstream feeder of the retirement monitor. Queues issued instructions in order and keeps a

---
 rtl/bitty_pkg.sv | 9 +
 rtl/bitty_instr_fifo.sv | 67 ++++++
 rtl/bitty_retire_tracker.sv | 105 ++++++++++
 3 files changed

// File: rtl/bitty_pkg.sv
// rtl/bitty_pkg.sv - shared widths for the bitty core, retire tracker and retirement monitor
package bitty_pkg;

    localparam int INSTR_W    = 16;
    localparam int REG_W      = 16;
    localparam int NUM_REGS   = 8;
    localparam int REG_ADDR_W = 3;

endpackage

// File: rtl/bitty_instr_fifo.sv
// rtl/bitty_instr_fifo.sv - in-order queue of issued instruction words awaiting retirement
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   push         write push_data (ignored while full)
//   push_data    word to enqueue
//   pop          remove head (ignored while empty)
//   pop_data     current head word, valid whenever empty=0
//   full, empty  occupancy flags decoded from the registered count
module bitty_instr_fifo #(
    parameter int W     = 16,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] pop_data,
    output logic         full,
    output logic         empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          push_ok;
    logic          pop_ok;

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign push_ok  = push && !full;
    assign pop_ok   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    // Storage carries no reset; only the pointers/count define validity.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/bitty_retire_tracker.sv
// rtl/bitty_retire_tracker.sv - queues issued instructions and publishes a register snapshot per retire
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   issue_valid/issue_instr    instruction issued by the core
//   issue_ready                queue has room (not full)
//   retire                     oldest in-flight instruction completes
//   wb_en/wb_addr/wb_data      write-back of the retiring instruction
//   done                       one-cycle pulse, snapshot outputs valid
//   instruction, reg0..reg7    retired word and post-retire shadow registers (held between retires)
//   overflow_err               sticky: issue while full
//   underflow_err              sticky: retire while empty
module bitty_retire_tracker #(
    parameter int INSTR_W = bitty_pkg::INSTR_W,
    parameter int REG_W   = bitty_pkg::REG_W,
    parameter int DEPTH   = 4
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            issue_valid,
    input  logic [INSTR_W-1:0]              issue_instr,
    output logic                            issue_ready,
    input  logic                            retire,
    input  logic                            wb_en,
    input  logic [bitty_pkg::REG_ADDR_W-1:0] wb_addr,
    input  logic [REG_W-1:0]                wb_data,
    output logic                            done,
    output logic [INSTR_W-1:0]              instruction,
    output logic [REG_W-1:0]                reg0,
    output logic [REG_W-1:0]                reg1,
    output logic [REG_W-1:0]                reg2,
    output logic [REG_W-1:0]                reg3,
    output logic [REG_W-1:0]                reg4,
    output logic [REG_W-1:0]                reg5,
    output logic [REG_W-1:0]                reg6,
    output logic [REG_W-1:0]                reg7,
    output logic                            overflow_err,
    output logic                            underflow_err
);

    import bitty_pkg::*;

    logic [INSTR_W-1:0] head_instr;
    logic               fifo_full;
    logic               fifo_empty;
    logic               pop_ok;
    logic [REG_W-1:0]   shadow [NUM_REGS];

    // The queue itself gates push on full and pop on empty; the same
    // qualification is repeated here for the done pulse and error flags.
    bitty_instr_fifo #(
        .W     (INSTR_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (issue_valid),
        .push_data (issue_instr),
        .pop       (retire),
        .pop_data  (head_instr),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign issue_ready = !fifo_full;
    assign pop_ok      = retire && !fifo_empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done          <= 1'b0;
            instruction   <= '0;
            overflow_err  <= 1'b0;
            underflow_err <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) begin
                shadow[i] <= '0;
            end
        end else begin
            done <= pop_ok;
            if (pop_ok) begin
                instruction <= head_instr;
                if (wb_en) begin
                    shadow[wb_addr] <= wb_data;
                end
            end
            if (issue_valid && fifo_full) begin
                overflow_err <= 1'b1;
            end
            if (retire && fifo_empty) begin
                underflow_err <= 1'b1;
            end
        end
    end

    // Shadow registers only change on a retire, so they double as the
    // held snapshot outputs.
    assign reg0 = shadow[0];
    assign reg1 = shadow[1];
    assign reg2 = shadow[2];
    assign reg3 = shadow[3];
    assign reg4 = shadow[4];
    assign reg5 = shadow[5];
    assign reg6 = shadow[6];
    assign reg7 = shadow[7];

endmodule
